truth_table_sweeper: RTL and testbench

//  - Upstream stimulus/capture stage for the 4-input combinational function F(A,B,C,D).
//  - On start, drives every ABCD vector 0..15 into the function, waits a settle window, and samples F.
//  - Builds a 16-bit truth table from the samples and checks it against the expected

---
 rtl/sweeper_pkg.sv | 32 +++
 rtl/sweep_settle_timer.sv | 47 ++++
 rtl/truth_table_sweeper.sv | 160 ++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweeper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sweeper_pkg
// Purpose  : Shared types, constants and helpers for the truth-table sweeper.
//            - state_t        : sweep FSM states (2-bit encoding)
//            - EXP_TT_DEFAULT : expected table for F = PI M(0,1,2,8,10,12,14)
//            - popcount16     : number of set bits in a 16-bit word
// Revision : 1.0 - initial release
// ============================================================================
package sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Bit i is F at {A,B,C,D} == i; zeros sit exactly on the maxterms.
  localparam logic [15:0] EXP_TT_DEFAULT = 16'hAAF8;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage : sweeper_pkg
`default_nettype wire

// File: rtl/sweep_settle_timer.sv
`default_nettype none
// ============================================================================
// Module   : sweep_settle_timer
// Purpose  : 8-bit loadable down-counter that times the settle window of
//            each stimulus vector.
// Ports    : clk         in   clock, rising edge
//            rst         in   asynchronous reset, active-high
//            load_i      in   load load_val_i into the counter
//            load_val_i  in   8  reload value (settle cycles - 1)
//            en_i        in   count enable
//            expire_o    out  high for one cycle when the enabled count is 0
// Revision : 1.0 - initial release
// ============================================================================
module sweep_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       en_i,
  output logic       expire_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // The counter is loaded with N-1, so expiry lands in the N-th enabled cycle.
  assign expire_o = en_i && !load_i && (count_q == 8'd0);

endmodule : sweep_settle_timer
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sweeper
// Purpose  : Drives every ABCD vector into a 4-input function block, waits a
//            settle window per vector, samples F into a 16-bit truth table and
//            compares the table against EXP_TT.
// Ports    : clk             in   clock, rising edge
//            rst             in   asynchronous reset, active-high
//            start           in   sweep request, sampled only in IDLE
//            F               in   output of the function block under test
//            A,B,C,D         out  stimulus vector, A = MSB
//            busy            out  high from start acceptance until DONE is left
//            done            out  one-cycle pulse, results valid
//            tt              out  16  captured truth table
//            mismatch_count  out  5   popcount(tt ^ EXP_TT)
//            pass            out  mismatch_count == 0
// Params   : STEP_CYCLES     settle cycles per vector (1..255)
//            EXP_TT          expected truth table
// Macro    : SWEEP_GRAY_EN   defined -> vectors visited in Gray order,
//                            undefined -> plain binary order
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int unsigned  STEP_CYCLES = 1,
  parameter logic [15:0]  EXP_TT      = EXP_TT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        F,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic [4:0]  mismatch_count,
  output logic        pass
);

  localparam logic [7:0] TIMER_LOAD = 8'(STEP_CYCLES - 1);
  localparam logic [3:0] LAST_IDX   = 4'd15;

  // Maps the sweep index to the vector actually driven.
  function automatic logic [3:0] order(input logic [3:0] i);
`ifdef SWEEP_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  idx_q,   idx_d;
  logic [3:0]  abcd_q,  abcd_d;
  logic [15:0] tt_q,    tt_d;
  logic [4:0]  mm_q,    mm_d;
  logic        pass_q,  pass_d;

  logic        tmr_load;
  logic        tmr_en;
  logic        tmr_expire;

  sweep_settle_timer u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (TIMER_LOAD),
    .en_i       (tmr_en),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    abcd_d   = abcd_q;
    tt_d     = tt_q;
    mm_d     = mm_q;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SETTLE;
          idx_d    = 4'd0;
          abcd_d   = order(4'd0);
          tt_d     = 16'h0000;
          mm_d     = 5'd0;
          pass_d   = 1'b0;
          tmr_load = 1'b1;
        end
      end

      SETTLE: begin
        tmr_en = 1'b1;
        if (tmr_expire) begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        // Index by the driven vector, not the sweep index, so the table
        // layout is the same in either visiting order.
        tt_d[abcd_q] = F;
        if (idx_q == LAST_IDX) begin
          // Score the completed table here so results are valid while
          // done is high.
          state_d = DONE;
          mm_d    = popcount16(tt_d ^ EXP_TT);
          pass_d  = (mm_d == 5'd0);
        end else begin
          state_d  = SETTLE;
          idx_d    = idx_q + 4'd1;
          abcd_d   = order(idx_q + 4'd1);
          tmr_load = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      abcd_q  <= 4'd0;
      tt_q    <= 16'h0000;
      mm_q    <= 5'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      abcd_q  <= abcd_d;
      tt_q    <= tt_d;
      mm_q    <= mm_d;
      pass_q  <= pass_d;
    end
  end

  assign {A, B, C, D}   = abcd_q;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign tt             = tt_q;
  assign mismatch_count = mm_q;
  assign pass           = pass_q;

endmodule : truth_table_sweeper
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_truth_table_sweeper
// Purpose  : Self-checking bench for truth_table_sweeper. A behavioural
//            function block (table lookup) closes the loop; expectations come
//            from the maxterm list, a Gray-code table and simple counting.
// Revision : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

`ifdef SWEEP_GRAY_EN
  localparam int STEP = 3;
`else
  localparam int STEP = 1;
`endif
  localparam int P   = STEP + 1;   // cycles per vector
  localparam int N   = 16 * P;     // edges from acceptance to DONE
  localparam int LIM = N + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        F;
  logic        A, B, C, D;
  logic        busy, done, pass;
  logic [15:0] tt;
  logic [4:0]  mm;
  logic [15:0] f_table = 16'h0000;

  always #5 clk = ~clk;

  // Function block under test: arbitrary 16-entry lookup.
  assign F = f_table[{A, B, C, D}];

  truth_table_sweeper #(
    .STEP_CYCLES (STEP),
    .EXP_TT      (16'hAAF8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .F              (F),
    .A              (A),
    .B              (B),
    .C              (C),
    .D              (D),
    .busy           (busy),
    .done           (done),
    .tt             (tt),
    .mismatch_count (mm),
    .pass           (pass)
  );

  int n_vec = 0;
  int n_err = 0;

  // Per-cycle observations of one sweep (index = edges after acceptance).
  logic [3:0]  o_abcd [0:LIM];
  logic        o_done [0:LIM];
  logic        o_busy [0:LIM];
  logic [15:0] o_tt   [0:LIM];
  int          done_j;
  int          n_done;
  logic [15:0] r_tt;
  logic [4:0]  r_mm;
  logic        r_pass;

  logic [3:0] GRAY [0:15] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                              4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  function automatic logic [3:0] exp_vec(int i);
`ifdef SWEEP_GRAY_EN
    return GRAY[i];
`else
    return 4'(i);
`endif
  endfunction

  // F = PI M(0,1,2,8,10,12,14): zero on the maxterms, one elsewhere.
  function automatic logic [15:0] golden_table();
    logic [15:0] t;
    for (int i = 0; i < 16; i++) begin
      t[i] = !(i inside {0, 1, 2, 8, 10, 12, 14});
    end
    return t;
  endfunction

  function automatic int diff_count(logic [15:0] t);
    logic [15:0] e;
    int n;
    e = 16'hAAF8;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (t[i] != e[i]) n++;
    end
    return n;
  endfunction

  function automatic int ones(logic [3:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (v[i]) n++;
    return n;
  endfunction

  // Launch one sweep and record LIM+1 cycles of outputs. Optional extra
  // start pulse at cycle pulse_at; hold keeps start asserted throughout.
  task automatic run_sweep(input int pulse_at, input bit hold);
    n_done = 0;
    done_j = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int j = 0; j <= LIM; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      o_abcd[j] = {A, B, C, D};
      o_done[j] = done;
      o_busy[j] = busy;
      o_tt[j]   = tt;
      if (done === 1'b1) begin
        n_done++;
        if (done_j < 0) begin
          done_j = j;
          r_tt   = tt;
          r_mm   = mm;
          r_pass = pass;
        end
      end
      if (j == 0 && !hold) start = 1'b0;
      if (pulse_at > 0 && j == pulse_at) start = 1'b1;
      if (pulse_at > 0 && j == pulse_at + 1) start = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({A, B, C, D, busy, done, pass, tt, mm} !== 24'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 000000", {A, B, C, D, busy, done, pass, tt, mm});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if ({busy, done} !== 2'b00) begin
        n_err++;
        $display("FAIL idle_quiet[%0d]: busy/done got %b expected 00", k, {busy, done});
      end
    end
  endtask

  task automatic test_golden();
    logic [15:0] g;
    g = golden_table();
    f_table = g;
    run_sweep(0, 1'b0);
    n_vec++;
    if (done_j != N) begin
      n_err++;
      $display("FAIL golden_done_cycle: got %0d expected %0d", done_j, N);
    end
    n_vec++;
    if (n_done != 1) begin
      n_err++;
      $display("FAIL golden_done_pulses: got %0d expected 1", n_done);
    end
    for (int j = 0; j < N; j++) begin
      n_vec++;
      if (o_abcd[j] !== exp_vec(j / P) || o_busy[j] !== 1'b1) begin
        n_err++;
        $display("FAIL golden_vector[%0d]: abcd/busy got %h/%b expected %h/1",
                 j, o_abcd[j], o_busy[j], exp_vec(j / P));
      end
    end
`ifdef SWEEP_GRAY_EN
    for (int j = P; j < N; j += P) begin
      n_vec++;
      if (ones(o_abcd[j] ^ o_abcd[j - P]) != 1) begin
        n_err++;
        $display("FAIL gray_single_toggle[%0d]: got %h after %h", j, o_abcd[j], o_abcd[j - P]);
      end
    end
`endif
    n_vec++;
    if (r_tt !== g || r_tt !== 16'hAAF8) begin
      n_err++;
      $display("FAIL golden_tt: got %h expected %h", r_tt, 16'hAAF8);
    end
    n_vec++;
    if (r_mm !== 5'd0 || r_pass !== 1'b1) begin
      n_err++;
      $display("FAIL golden_score: mm/pass got %0d/%b expected 0/1", r_mm, r_pass);
    end
    n_vec++;
    if (o_busy[N + 1] !== 1'b0 || o_done[N + 1] !== 1'b0) begin
      n_err++;
      $display("FAIL golden_after_done: busy/done got %b/%b expected 0/0", o_busy[N + 1], o_done[N + 1]);
    end
    n_vec++;
    if (o_tt[N + 2] !== g || o_abcd[N + 2] !== exp_vec(15)) begin
      n_err++;
      $display("FAIL golden_hold: tt/abcd got %h/%h expected %h/%h", o_tt[N + 2], o_abcd[N + 2], g, exp_vec(15));
    end
    n_vec++;
    if (mm !== 5'd0 || pass !== 1'b1) begin
      n_err++;
      $display("FAIL golden_result_hold: mm/pass got %0d/%b expected 0/1", mm, pass);
    end
  endtask

  task automatic test_stuck0();
    f_table = 16'h0000;
    run_sweep(0, 1'b0);
    n_vec++;
    if (done_j != N || r_tt !== 16'h0000 || r_mm !== 5'd9 || r_pass !== 1'b0) begin
      n_err++;
      $display("FAIL stuck0: done/tt/mm/pass got %0d/%h/%0d/%b expected %0d/0000/9/0",
               done_j, r_tt, r_mm, r_pass, N);
    end
  endtask

  task automatic test_random();
    logic [15:0] t;
    for (int r = 0; r < 6; r++) begin
      t = 16'($urandom);
      if (r == 0) t = 16'hFFFF;
      f_table = t;
      run_sweep(0, 1'b0);
      n_vec++;
      if (done_j != N || r_tt !== t || int'(r_mm) != diff_count(t) ||
          r_pass !== (diff_count(t) == 0)) begin
        n_err++;
        $display("FAIL random[%0d]: done/tt/mm/pass got %0d/%h/%0d/%b expected %0d/%h/%0d/%b",
                 r, done_j, r_tt, r_mm, r_pass, N, t, diff_count(t), diff_count(t) == 0);
      end
    end
  endtask

  task automatic test_start_pulse();
    f_table = golden_table();
    run_sweep(10, 1'b0);
    n_vec++;
    if (n_done != 1 || done_j != N || o_busy[N + 1] !== 1'b0 || o_busy[N + 3] !== 1'b0) begin
      n_err++;
      $display("FAIL start_ignored: dones/done_cycle/busy got %0d/%0d/%b%b expected 1/%0d/00",
               n_done, done_j, o_busy[N + 1], o_busy[N + 3], N);
    end
    n_vec++;
    if (r_tt !== 16'hAAF8) begin
      n_err++;
      $display("FAIL start_ignored_tt: got %h expected aaf8", r_tt);
    end
  endtask

  task automatic test_start_held();
    int k;
    f_table = 16'h0000;
    run_sweep(0, 1'b1);
    n_vec++;
    if (o_busy[N + 1] !== 1'b0 || o_done[N + 1] !== 1'b0) begin
      n_err++;
      $display("FAIL held_idle_gap: busy/done got %b/%b expected 0/0", o_busy[N + 1], o_done[N + 1]);
    end
    n_vec++;
    if (o_busy[N + 2] !== 1'b1 || o_tt[N + 2] !== 16'h0000 || o_abcd[N + 2] !== exp_vec(0)) begin
      n_err++;
      $display("FAIL held_restart: busy/tt/abcd got %b/%h/%h expected 1/0000/%h",
               o_busy[N + 2], o_tt[N + 2], o_abcd[N + 2], exp_vec(0));
    end
    // Change the function mid-way: the second sweep must see it from vector 0.
    f_table = golden_table();
    start = 1'b0;
    k = LIM;
    while (done !== 1'b1 && k < 3 * N) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_vec++;
    if (done !== 1'b1 || k != 2 * N + 2) begin
      n_err++;
      $display("FAIL held_second_done: done/cycle got %b/%0d expected 1/%0d", done, k, 2 * N + 2);
    end
    // First 16 samples went into the first sweep's table, so only a full
    // second sweep yields the golden table here.
    n_vec++;
    if (tt !== 16'hAAF8 || pass !== 1'b1) begin
      n_err++;
      $display("FAIL held_second_result: tt/pass got %h/%b expected aaf8/1", tt, pass);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_abort();
    int k;
    f_table = golden_table();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while ({A, B, C, D} !== 4'd7 && k < N) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_vec++;
    if ({A, B, C, D} !== 4'd7 || tt === 16'h0000) begin
      n_err++;
      $display("FAIL abort_reach7: abcd/tt got %h/%h expected 7/nonzero", {A, B, C, D}, tt);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({A, B, C, D, busy, done, pass, tt, mm} !== 24'd0) begin
      n_err++;
      $display("FAIL abort_cleared: got %h expected 000000", {A, B, C, D, busy, done, pass, tt, mm});
    end
    @(negedge clk);
    rst = 1'b0;
    run_sweep(0, 1'b0);
    n_vec++;
    if (done_j != N || r_tt !== 16'hAAF8 || r_mm !== 5'd0 || r_pass !== 1'b1) begin
      n_err++;
      $display("FAIL abort_resweep: done/tt/mm/pass got %0d/%h/%0d/%b expected %0d/aaf8/0/1",
               done_j, r_tt, r_mm, r_pass, N);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_golden();
    test_stuck0();
    test_random();
    test_start_pulse();
    test_start_held();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_truth_table_sweeper
`default_nettype wire
